// File: rtl/reaction_stimulus_gen.sv
// Millisecond timebase with clear/freeze and an LFSR-driven one-hot button request source
// for the reaction-timer game FSM.
module reaction_stimulus_gen #(
    parameter int unsigned CLK_PER_MS = 50000,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter bit          NO_REPEAT  = 1'b1
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic        iResetTimer,
    input  logic        iNewButtonReq,
    input  logic        iFreeze,
    output logic [15:0] oTimer16,
    output logic [15:0] oFrozenTimer16,
    output logic [2:0]  oButtonRequested,
    output logic        oMsTick
);

    localparam logic [19:0] PreMax   = 20'(CLK_PER_MS - 1);
    localparam logic [15:0] LfsrInit = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] LfsrMask = 16'hB400;

    logic [19:0] presc_q, presc_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] frozen_q, frozen_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [2:0]  btn_q, btn_d;
    logic        tick_q, tick_d;

    logic        presc_wrap;
    logic [2:0]  btn_rot;
    logic [2:0]  btn_cand;

    always_comb begin
        presc_wrap = (presc_q == PreMax);
        presc_d    = presc_wrap ? 20'd0 : presc_q + 20'd1;
        timer_d    = timer_q;
        tick_d     = 1'b0;
        if (presc_wrap) begin
            timer_d = (timer_q != 16'hFFFF) ? timer_q + 16'd1 : timer_q;
            tick_d  = 1'b1;
        end
        // Clear wins over a coincident millisecond tick.
        if (iResetTimer) begin
            presc_d = 20'd0;
            timer_d = 16'd0;
            tick_d  = 1'b0;
        end
    end

    // Snapshot uses the pre-update timer, so the display lags by one cycle.
    always_comb begin
        frozen_d = iFreeze ? frozen_q : timer_q;
    end

    // Free-running so the moment of each request, set by the player, picks the state.
    always_comb begin
        lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LfsrMask : 16'h0000);
    end

    always_comb begin
        btn_rot = {btn_q[1:0], btn_q[2]};
        unique case (lfsr_q[1:0])
            2'b00:   btn_cand = 3'b001;
            2'b01:   btn_cand = 3'b010;
            2'b10:   btn_cand = 3'b100;
            default: btn_cand = btn_rot;
        endcase
        if (NO_REPEAT && (btn_cand == btn_q)) begin
            btn_cand = btn_rot;
        end
        btn_d = iNewButtonReq ? btn_cand : btn_q;
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            presc_q  <= 20'd0;
            timer_q  <= 16'd0;
            frozen_q <= 16'd0;
            tick_q   <= 1'b0;
            btn_q    <= 3'b001;
            lfsr_q   <= LfsrInit;
        end else begin
            presc_q  <= presc_d;
            timer_q  <= timer_d;
            frozen_q <= frozen_d;
            tick_q   <= tick_d;
            btn_q    <= btn_d;
            lfsr_q   <= lfsr_d;
        end
    end

    assign oTimer16         = timer_q;
    assign oFrozenTimer16   = frozen_q;
    assign oButtonRequested = btn_q;
    assign oMsTick          = tick_q;

endmodule

// File: doc/reaction_stimulus_gen.md
Name: reaction_stimulus_gen

Overview:
Stimulus and timebase source for the reaction-timer game. It runs a millisecond timer, with clear and freeze controls, that feeds the game FSM's elapsed-time input. It also generates the one-hot requested-button value from a free-running LFSR each time the FSM asks for a new button. It is the opposite end of the FSM's timer/button-request interface: it consumes the FSM's reset-timer, new-request and freeze strobes and drives the time and requested-button inputs back to it.

Parameters:
CLK_PER_MS, 50000, iClk cycles per millisecond; legal range 1..2^20.
LFSR_SEED, 16'hACE1, LFSR reset value; a seed of 0 is replaced by 16'h0001.
NO_REPEAT, 1, when 1 a new request never equals the previous request.

Ports:
iClk  input  1  system clock, rising-edge active.
iRst_n  input  1  asynchronous, active-low reset.
iResetTimer  input  1  synchronous clear of prescaler and timer (level; acts on every edge it is high).
iNewButtonReq  input  1  load a new requested button on the next edge.
iFreeze  input  1  1 = hold oFrozenTimer16; 0 = oFrozenTimer16 tracks oTimer16.
oTimer16  output  16  elapsed milliseconds since last clear; saturating.
oFrozenTimer16  output  16  snapshot of oTimer16 for the display.
oButtonRequested  output  3  one-hot requested button: 001 = button 0, 010 = button 1, 100 = button 2.
oMsTick  output  1  one-cycle pulse, registered, marking each millisecond increment.

Behaviour:
- One clock domain. All state is in flops. iRst_n low forces state immediately, without a clock edge.
- Reset values: prescaler 0, oTimer16 0, oFrozenTimer16 0, oMsTick 0, oButtonRequested 3'b001, lfsr LFSR_SEED (or 1 if the seed is 0).
- Prescaler (20 bits):
  - Counts 0..CLK_PER_MS-1, then wraps to 0.
  - On the edge where prescaler == CLK_PER_MS-1: oTimer16 <= oTimer16+1, saturating at 16'hFFFF (never wraps), and oMsTick <= 1.
  - On all other edges oMsTick <= 0.
  - With CLK_PER_MS = 1, oTimer16 increments every cycle and oMsTick is held at 1.
- iResetTimer high at an edge:
  - prescaler <= 0, oTimer16 <= 0, oMsTick <= 0.
  - Has priority over a coincident tick.
  - The first increment after release occurs CLK_PER_MS edges after the last clearing edge.
- Freeze:
  - iFreeze = 0 at an edge: oFrozenTimer16 <= oTimer16, i.e. the value before that edge's update, so it lags by one cycle.
  - iFreeze = 1: oFrozenTimer16 holds.
  - iResetTimer does not clear oFrozenTimer16.
- LFSR:
  - 16-bit Galois, right-shift, mask 16'hB400 (x^16+x^14+x^13+x^11+1).
  - Each edge: lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 0).
  - Advances every clock regardless of other inputs, so human reaction timing supplies entropy.
- New request (iNewButtonReq high at an edge) uses the pre-advance lfsr[1:0]:
  - 00 -> 001, 01 -> 010, 10 -> 100.
  - 11 -> the current oButtonRequested rotated left by 1 (100 -> 001).
  - If NO_REPEAT = 1 and the candidate equals the current oButtonRequested, load the current value rotated left by 1 instead.
  - The new value appears the cycle after the strobe edge. The output is always exactly one-hot.
- Simultaneous iResetTimer and iNewButtonReq (the FSM asserts both in its display-button state): both take effect on the same edge, independently.
- iNewButtonReq held for N edges produces N successive updates.
- Reset asserted mid-count or mid-request: all state returns to reset values immediately; no partial update survives.

Test Plan:
1. Run with CLK_PER_MS = 4. Assert iRst_n low asynchronously between edges while oTimer16 = 9 -> all outputs go to reset values before the next edge, oButtonRequested = 001; release, run 3 edges -> oTimer16 = 0.
2. CLK_PER_MS = 4: pulse iResetTimer for 1 edge, then 40 edges -> oTimer16 = 10, with oMsTick high on exactly 10 single cycles spaced 4 apart; iResetTimer at oTimer16 = 123 coincident with a tick -> oTimer16 = 0 next cycle, oMsTick = 0.
3. CLK_PER_MS = 1: clear, run 70000 edges -> oTimer16 reaches 16'hFFFF at edge 65535 and stays there; oMsTick remains 1.
4. Seed 16'hACE1: check the lfsr after 1 edge = 16'hE270 and compare the next 64 states against a bench model. Assert iNewButtonReq together with iResetTimer when the pre-edge lfsr[1:0] = 01 and current button 001 -> oButtonRequested = 010 and oTimer16 = 0 on the same cycle.
5. NO_REPEAT = 1: issue 1000 requests at random spacing -> every output is one-hot, no two consecutive values are equal, and each button appears at least 250 times. NO_REPEAT = 0 with pre-edge lfsr[1:0] = 00 and current 001 -> stays 001.
6. Freeze: iFreeze = 0 while counting; raise iFreeze when oFrozenTimer16 = 7 -> it holds 7 while oTimer16 reaches 20 and survives an iResetTimer pulse; drop iFreeze -> the next cycle oFrozenTimer16 equals the previous-cycle oTimer16.
